// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake, issues to decode.
// Optional build macro FETCH_STATS_EN adds retired/taken instruction counters.
module fetch_unit #(
   parameter int unsigned         PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned         CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [PC_WIDTH-1:0]  imem_rdata,
   output logic [PC_WIDTH-1:0]  instr,
   output logic                 instr_valid,
   input  logic                 stall,
   input  logic                 Jump,
   input  logic                 Branch,
   input  logic                 Zero,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  pc_plus4
`ifdef FETCH_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] instr_count,
   output logic [CNT_WIDTH-1:0] taken_count
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                load_instr;
   logic                advance;
   logic                taken;
   logic [PC_WIDTH-1:0] branch_off;
   logic [PC_WIDTH-1:0] jump_target;
   logic [PC_WIDTH-1:0] next_pc;

   assign imem_addr = pc;
   assign pc_plus4  = pc + PC_WIDTH'(4);

   // Next-PC selection; Jump outranks a taken branch.
   assign taken       = Jump | (Branch & Zero);
   assign branch_off  = PC_WIDTH'($signed(instr[15:0])) << 2;
   assign jump_target = {pc_plus4[PC_WIDTH-1:28], instr[25:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = jump_target;
      end else if (Branch && Zero) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   // Next-state logic; acks are only honoured in FETCH.
   always_comb begin
      state_d    = state_q;
      load_instr = 1'b0;
      advance    = 1'b0;
      case (state_q)
         BOOT:  state_d = FETCH;
         FETCH: begin
            if (imem_ack) begin
               load_instr = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) begin
               advance = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // Request and valid are registered from the next state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc          <= RESET_PC;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         imem_req    <= (state_d == FETCH);
         instr_valid <= (state_d == ISSUE);
         if (load_instr) begin
            instr <= imem_rdata;
         end
         if (advance) begin
            pc <= next_pc;
         end
      end
   end

`ifdef FETCH_STATS_EN
   // Retired and redirected instruction counters, wrapping freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
         taken_count <= '0;
      end else if (advance) begin
         instr_count <= instr_count + CNT_WIDTH'(1);
         if (taken) begin
            taken_count <= taken_count + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule
